// File: rtl/vpu_seq_pkg.sv
// Shared definitions for the VPU instruction sequencer: opcodes, field positions, FSM states.
// VPU_SEQ_SINGLE_STEP_EN adds the STEP_WAIT state used for single-step debug.
package vpu_seq_pkg;

    localparam logic [3:0] OP_HALT    = 4'hF;
    localparam logic [3:0] OP_JMP     = 4'hE;
    localparam logic [3:0] OP_LOOPSET = 4'hD;
    localparam logic [3:0] OP_DJNZ    = 4'hC;
    localparam logic [3:0] OP_NOP     = 4'h0;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;

`ifdef VPU_SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_ISSUE,
        S_DONE,
        S_STEP_WAIT
    } seq_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_ISSUE,
        S_DONE
    } seq_state_t;
`endif

endpackage

// File: rtl/vpu_instr_sequencer.sv
// Fetches instructions, resolves HALT/JMP/LOOPSET/DJNZ/NOP locally and issues the rest to the datapath.
// Optional single-step debug via `define VPU_SEQ_SINGLE_STEP_EN (adds step input and STEP_WAIT).
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | rd_addr = PC presented to instruction memory
// LATCH     | IR <= rd_data
// EXEC      | resolve control/NOP opcodes, or hand datapath opcodes to ISSUE
// ISSUE     | issue_valid high until issue_ready
// DONE      | HALT reached; done held until next start
// STEP_WAIT | (single-step build) hold until a step pulse
module vpu_instr_sequencer
    import vpu_seq_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 256,
    parameter int LOOP_W      = 8,
    localparam int PC_W       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
`ifdef VPU_SEQ_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic [PC_W-1:0]        rd_addr,
    input  logic [INSTR_WIDTH-1:0] rd_data,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [INSTR_WIDTH-1:0] issue_instr,
    output logic                   busy,
    output logic                   done,
    output logic [PC_W-1:0]        pc_out
);

`ifdef VPU_SEQ_SINGLE_STEP_EN
    localparam seq_state_t S_RESUME = S_STEP_WAIT;
`else
    localparam seq_state_t S_RESUME = S_FETCH;
`endif

    seq_state_t             state;
    logic [PC_W-1:0]        pc;
    logic [INSTR_WIDTH-1:0] ir;
    logic [LOOP_W-1:0]      loop_cnt;

    logic [3:0]             opcode;
    logic [PC_W-1:0]        target;
    logic [PC_W-1:0]        pc_inc;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign target = ir[PC_W-1:0];
    // Explicit wrap keeps PC modulo DEPTH even when DEPTH is not a power of two.
    assign pc_inc = (pc == PC_W'(DEPTH - 1)) ? '0 : pc + PC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            loop_cnt <= '0;
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    ir    <= rd_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_HALT: state <= S_DONE;
                        OP_JMP: begin
                            pc    <= target;
                            state <= S_RESUME;
                        end
                        OP_LOOPSET: begin
                            loop_cnt <= ir[LOOP_W-1:0];
                            pc       <= pc_inc;
                            state    <= S_RESUME;
                        end
                        OP_DJNZ: begin
                            if (loop_cnt != '0) begin
                                loop_cnt <= loop_cnt - LOOP_W'(1);
                                pc       <= target;
                            end else begin
                                pc <= pc_inc;
                            end
                            state <= S_RESUME;
                        end
                        OP_NOP: begin
                            pc    <= pc_inc;
                            state <= S_RESUME;
                        end
                        default: state <= S_ISSUE;
                    endcase
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        pc    <= pc_inc;
                        state <= S_RESUME;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        pc    <= '0;
                        state <= S_FETCH;
                    end
                end
`ifdef VPU_SEQ_SINGLE_STEP_EN
                S_STEP_WAIT: begin
                    if (step) state <= S_FETCH;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs come straight from the state register or datapath registers.
    always_comb begin
        rd_addr     = pc;
        pc_out      = pc;
        issue_instr = ir;
        issue_valid = (state == S_ISSUE);
        done        = (state == S_DONE);
        busy        = (state != S_IDLE) && (state != S_DONE);
    end

endmodule

// File: tb/tb_vpu_instr_sequencer.sv
// Self-checking bench for vpu_instr_sequencer: ISA-level program model plus directed programs.
module tb_vpu_instr_sequencer;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst, start, abort, issue_ready;
    logic [7:0]  rd_addr, pc_out;
    logic [31:0] rd_data, issue_instr;
    logic        issue_valid, busy, done;
`ifdef VPU_SEQ_SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    vpu_instr_sequencer #(.INSTR_WIDTH(32), .DEPTH(DEPTH), .LOOP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef VPU_SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .rd_addr(rd_addr), .rd_data(rd_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .busy(busy), .done(done), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ISA-level reference: walks the program image and lists what must be issued.
    logic [31:0] model_q[$];
    int          model_cycles;
    int          model_cnt;

    function automatic void isa_run();
        int pc = 0;
        int cnt = 0;
        int n_instr = 0;
        bit halted = 0;
        logic [31:0] ins;
        model_q.delete();
        while (!halted && n_instr < 2000) begin
            ins = mem[pc];
            n_instr++;
            case (ins[31:28])
                4'hF: halted = 1;
                4'hE: pc = int'(ins[7:0]);
                4'hD: begin cnt = int'(ins[7:0]); pc = (pc + 1) % DEPTH; end
                4'hC: begin
                    if (cnt != 0) begin cnt = cnt - 1; pc = int'(ins[7:0]); end
                    else pc = (pc + 1) % DEPTH;
                end
                4'h0: pc = (pc + 1) % DEPTH;
                default: begin model_q.push_back(ins); pc = (pc + 1) % DEPTH; end
            endcase
        end
        // Three cycles per instruction plus one ISSUE cycle per datapath op.
        model_cycles = 3 * n_instr + model_q.size();
        model_cnt    = cnt;
    endfunction

    // Per-cycle monitor: issued instruction order and stall stability.
    logic [31:0] exp_q[$];
    bit          mon_en = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_instr = '0;
    logic [7:0]  prev_pc = '0;
    int          n_acc = 0;
    int          n_stall = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("rd_addr_eq_pc", 32'(rd_addr), 32'(pc_out));
            check("busy_done_exclusive", 32'(busy && done), 32'd0);
            if (prev_stall) begin
                check("stall_valid_held", 32'(issue_valid), 32'd1);
                check("stall_instr_held", issue_instr, prev_instr);
                check("stall_pc_held", 32'(pc_out), 32'(prev_pc));
            end
            if (issue_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_issue: got 0x%0h, expected no issue", issue_instr);
                end else begin
                    check("issue_instr", issue_instr, exp_q[0]);
                    if (issue_ready && !abort) begin
                        void'(exp_q.pop_front());
                        n_acc++;
                    end
                end
                if (!issue_ready) n_stall++;
            end
            prev_stall = issue_valid && !issue_ready && !abort;
            prev_instr = issue_instr;
            prev_pc    = pc_out;
        end
    end

    // Ready driver: holds ready low for the first stall_left cycles of a pending issue.
    int stall_left = 0;
    initial begin
        issue_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (issue_valid && stall_left > 0) begin
                issue_ready = 1'b0;
                stall_left--;
            end else begin
                issue_ready = 1'b1;
            end
        end
    end

    int last_cycles;

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    endtask

    // Starts the loaded program and counts cycles from the start edge to done.
    task automatic run_prog(input string tag, input int stalls, input bit mid_start);
        int k;
        isa_run();
        exp_q = model_q;
        n_acc = 0;
        stall_left = stalls;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_done_cleared"}, 32'(done), 32'd0);
        k = 0;
        while (!done && k < 600) begin
            start = mid_start && (k == 4);
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        last_cycles = k;
        check({tag, "_done_reached"}, 32'(done), 32'd1);
        check({tag, "_cycles"}, 32'(k), 32'(model_cycles + stalls));
        check({tag, "_issue_count"}, 32'(n_acc), 32'(model_q.size()));
        check({tag, "_pending_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_issue_instr", issue_instr, 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_loop_cnt", 32'(dut.loop_cnt), 32'd0);
        mon_en = 1;

        // Two datapath ops then HALT; a start pulse mid-run must be ignored.
        mem[0] = 32'h1000_0001; mem[1] = 32'h2000_0002; mem[2] = 32'hF000_0000;
        isa_run();
        check("model_p1_cycles", 32'(model_cycles), 32'd11);
        check("model_p1_issues", 32'(model_q.size()), 32'd2);
        run_prog("p1", 0, 1);
        check("p1_start_to_done", 32'(last_cycles), 32'd11);
        repeat (3) @(posedge clk);
        #1;
        check("p1_done_held", 32'(done), 32'd1);
        check("p1_idle_busy", 32'(busy), 32'd0);

        // Restart from DONE re-executes from address 0.
        run_prog("p1_rerun", 0, 0);

        // First issue stalled for 5 cycles.
        n_stall = 0;
        run_prog("p2_stall", 5, 0);
        check("p2_stall_cycles", 32'(n_stall), 32'd5);
        check("p2_start_to_done", 32'(last_cycles), 32'd16);

        // Hardware loop: LOOPSET 3, body, DJNZ 1, HALT.
        clear_mem();
        mem[0] = 32'hD000_0003; mem[1] = 32'h1000_0000; mem[2] = 32'hC000_0001; mem[3] = 32'hF000_0000;
        isa_run();
        check("model_loop_issues", 32'(model_q.size()), 32'd4);
        check("model_loop_cycles", 32'(model_cycles), 32'd34);
        check("model_loop_cnt", 32'(model_cnt), 32'd0);
        run_prog("loop", 0, 0);
        check("loop_cnt_final", 32'(dut.loop_cnt), 32'(model_cnt));

        // JMP to 255, issue there, wrap to 0 where HALT has since been loaded.
        clear_mem();
        mem[0] = 32'hE000_00FF; mem[255] = 32'h1000_0000;
        exp_q.delete();
        exp_q.push_back(32'h1000_0000);
        n_acc = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!issue_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("jmp_issue_seen", 32'(issue_valid), 32'd1);
        check("jmp_issue_pc", 32'(pc_out), 32'd255);
        mem[0] = 32'hF000_0000;
        @(posedge clk);
        #1;
        k++;
        check("jmp_wrap_pc", 32'(pc_out), 32'd0);
        check("jmp_valid_dropped", 32'(issue_valid), 32'd0);
        while (!done && k < 50) begin @(posedge clk); #1; k++; end
        check("jmp_done", 32'(done), 32'd1);
        check("jmp_start_to_done", 32'(k), 32'd10);
        check("jmp_issue_count", 32'(n_acc), 32'd1);

        // Abort during ISSUE with issue_ready high in the same cycle.
        clear_mem();
        mem[0] = 32'h1000_0001; mem[1] = 32'hF000_0000;
        exp_q.delete();
        exp_q.push_back(32'h1000_0001);
        n_acc = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!issue_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("abort_issue_seen", 32'(issue_valid), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_valid_low", 32'(issue_valid), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_done_low", 32'(done), 32'd0);
        check("abort_pc_held", 32'(pc_out), 32'd0);
        check("abort_no_accept", 32'(n_acc), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("abort_stays_idle", 32'(busy), 32'd0);

        // Restart from IDLE after abort.
        run_prog("post_abort", 0, 0);
        check("post_abort_start_to_done", 32'(last_cycles), 32'd7);

        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
